// File: rtl/writeback_unit_pkg.sv
// =====================================================================
// writeback_unit_pkg : shared core widths for the writeback stage
// Rev 1.0
// =====================================================================
`default_nettype none

package writeback_unit_pkg;

    localparam int XLEN_DEFAULT      = 32;
    localparam int REG_COUNT_DEFAULT = 32;

    function automatic int addr_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/wb_skid_buffer.sv
// =====================================================================
// wb_skid_buffer : single-entry holding slot for a deferred ALU write
// Rev 1.0
// =====================================================================
`default_nettype none

module wb_skid_buffer
    import writeback_unit_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT,
    parameter int AW   = addr_width(REG_COUNT_DEFAULT)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [AW-1:0]   in_rd,
    input  logic [XLEN-1:0] in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [AW-1:0]   out_rd,
    output logic [XLEN-1:0] out_data
);

    logic            full;
    logic [AW-1:0]   rd_q;
    logic [XLEN-1:0] data_q;

    // Fill and drain never coincide: a full slot refuses new entries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full   <= 1'b0;
            rd_q   <= '0;
            data_q <= '0;
        end else if (in_valid && in_ready) begin
            full   <= 1'b1;
            rd_q   <= in_rd;
            data_q <= in_data;
        end else if (out_ready && full) begin
            full   <= 1'b0;
        end
    end

    assign in_ready  = !full;
    assign out_valid = full;
    assign out_rd    = rd_q;
    assign out_data  = data_q;

endmodule

`default_nettype wire

// File: rtl/writeback_unit.sv
// =====================================================================
// writeback_unit : register-file write arbiter, load scoreboard, bypass
// Rev 1.0
// =====================================================================
`default_nettype none

module writeback_unit
    import writeback_unit_pkg::*;
#(
    parameter  int XLEN      = XLEN_DEFAULT,
    parameter  int REG_COUNT = REG_COUNT_DEFAULT,
    localparam int AW        = addr_width(REG_COUNT)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            alu_valid_i,
    output logic            alu_ready_o,
    input  logic [AW-1:0]   alu_rd_i,
    input  logic [XLEN-1:0] alu_data_i,
    input  logic            lsu_issue_i,
    input  logic [AW-1:0]   lsu_issue_rd_i,
    input  logic            lsu_valid_i,
    input  logic [AW-1:0]   lsu_rd_i,
    input  logic [XLEN-1:0] lsu_data_i,
    input  logic [AW-1:0]   dec_rs1_i,
    input  logic [AW-1:0]   dec_rs2_i,
    input  logic [AW-1:0]   dec_rd_i,
    input  logic [XLEN-1:0] rf_rs1_data_i,
    input  logic [XLEN-1:0] rf_rs2_data_i,
    output logic [XLEN-1:0] rs1_data_o,
    output logic [XLEN-1:0] rs2_data_o,
    output logic            hazard_o,
    output logic            write_en_o,
    output logic [AW-1:0]   write_addr_o,
    output logic [XLEN-1:0] write_data_o
);

    logic                 skid_in_ready;
    logic                 skid_full;
    logic [AW-1:0]        skid_rd;
    logic [XLEN-1:0]      skid_data;

    logic                 sel_valid;
    logic [AW-1:0]        sel_rd;
    logic [XLEN-1:0]      sel_data;

    logic [REG_COUNT-1:0] pending;
    logic [REG_COUNT-1:0] pending_next;

    // The skid only ever absorbs an ALU result that collides with a load.
    wb_skid_buffer #(
        .XLEN (XLEN),
        .AW   (AW)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (alu_valid_i && lsu_valid_i),
        .in_ready  (skid_in_ready),
        .in_rd     (alu_rd_i),
        .in_data   (alu_data_i),
        .out_valid (skid_full),
        .out_ready (!lsu_valid_i),
        .out_rd    (skid_rd),
        .out_data  (skid_data)
    );

    assign alu_ready_o = skid_in_ready;

    always_comb begin
        sel_valid = 1'b0;
        sel_rd    = '0;
        sel_data  = '0;
        if (lsu_valid_i) begin
            sel_valid = 1'b1;
            sel_rd    = lsu_rd_i;
            sel_data  = lsu_data_i;
        end else if (skid_full) begin
            sel_valid = 1'b1;
            sel_rd    = skid_rd;
            sel_data  = skid_data;
        end else if (alu_valid_i && alu_ready_o) begin
            sel_valid = 1'b1;
            sel_rd    = alu_rd_i;
            sel_data  = alu_data_i;
        end
    end

    // x0 writes consume their source but never reach the register file.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_en_o   <= 1'b0;
            write_addr_o <= '0;
            write_data_o <= '0;
        end else begin
            write_en_o <= sel_valid && (sel_rd != '0);
            if (sel_valid && (sel_rd != '0)) begin
                write_addr_o <= sel_rd;
                write_data_o <= sel_data;
            end
        end
    end

    // Set after clear so a new issue outranks a same-cycle return.
    always_comb begin
        pending_next = pending;
        if (lsu_valid_i) begin
            pending_next[lsu_rd_i] = 1'b0;
        end
        if (lsu_issue_i) begin
            pending_next[lsu_issue_rd_i] = 1'b1;
        end
        pending_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            pending <= pending_next;
        end
    end

    assign hazard_o = pending[dec_rs1_i] || pending[dec_rs2_i] || pending[dec_rd_i]
                   || (skid_full && (skid_rd != '0)
                       && ((skid_rd == dec_rs1_i) || (skid_rd == dec_rs2_i)));

    assign rs1_data_o = (write_en_o && (write_addr_o == dec_rs1_i) && (dec_rs1_i != '0))
                      ? write_data_o : rf_rs1_data_i;
    assign rs2_data_o = (write_en_o && (write_addr_o == dec_rs2_i) && (dec_rs2_i != '0))
                      ? write_data_o : rf_rs2_data_i;

endmodule

`default_nettype wire

// File: tb/tb_writeback_unit.sv
// =====================================================================
// tb_writeback_unit : directed vector table plus randomized model check
// Rev 1.0
// =====================================================================
`default_nettype none

module tb_writeback_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_valid_i;
    logic        alu_ready_o;
    logic [4:0]  alu_rd_i;
    logic [31:0] alu_data_i;
    logic        lsu_issue_i;
    logic [4:0]  lsu_issue_rd_i;
    logic        lsu_valid_i;
    logic [4:0]  lsu_rd_i;
    logic [31:0] lsu_data_i;
    logic [4:0]  dec_rs1_i, dec_rs2_i, dec_rd_i;
    logic [31:0] rf_rs1_data_i, rf_rs2_data_i;
    logic [31:0] rs1_data_o, rs2_data_o;
    logic        hazard_o;
    logic        write_en_o;
    logic [4:0]  write_addr_o;
    logic [31:0] write_data_o;

    int tests  = 0;
    int errors = 0;

    always #5 clk = ~clk;

    writeback_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .alu_valid_i    (alu_valid_i),
        .alu_ready_o    (alu_ready_o),
        .alu_rd_i       (alu_rd_i),
        .alu_data_i     (alu_data_i),
        .lsu_issue_i    (lsu_issue_i),
        .lsu_issue_rd_i (lsu_issue_rd_i),
        .lsu_valid_i    (lsu_valid_i),
        .lsu_rd_i       (lsu_rd_i),
        .lsu_data_i     (lsu_data_i),
        .dec_rs1_i      (dec_rs1_i),
        .dec_rs2_i      (dec_rs2_i),
        .dec_rd_i       (dec_rd_i),
        .rf_rs1_data_i  (rf_rs1_data_i),
        .rf_rs2_data_i  (rf_rs2_data_i),
        .rs1_data_o     (rs1_data_o),
        .rs2_data_o     (rs2_data_o),
        .hazard_o       (hazard_o),
        .write_en_o     (write_en_o),
        .write_addr_o   (write_addr_o),
        .write_data_o   (write_data_o)
    );

    typedef struct {
        logic        av;  logic [4:0] ard; logic [31:0] ad;
        logic        iv;  logic [4:0] ird;
        logic        lv;  logic [4:0] lrd; logic [31:0] ld;
        logic [4:0]  rs1; logic [4:0] rs2; logic [4:0] rd;
        logic [31:0] rf1; logic [31:0] rf2;
        logic        e_rdy; logic e_hz; logic e_we;
        logic [4:0]  e_wa;  logic [31:0] e_wd;
        logic [31:0] e_o1;  logic [31:0] e_o2;
    } vec_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] d;
    } ent_t;

    function automatic vec_t mk(
        input logic av, input logic [4:0] ard, input logic [31:0] ad,
        input logic iv, input logic [4:0] ird,
        input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
        input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
        input logic [31:0] rf1, input logic [31:0] rf2,
        input logic e_rdy, input logic e_hz, input logic e_we,
        input logic [4:0] e_wa, input logic [31:0] e_wd,
        input logic [31:0] e_o1, input logic [31:0] e_o2);
        vec_t v;
        v.av = av; v.ard = ard; v.ad = ad; v.iv = iv; v.ird = ird;
        v.lv = lv; v.lrd = lrd; v.ld = ld;
        v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.rf1 = rf1; v.rf2 = rf2;
        v.e_rdy = e_rdy; v.e_hz = e_hz; v.e_we = e_we;
        v.e_wa = e_wa; v.e_wd = e_wd; v.e_o1 = e_o1; v.e_o2 = e_o2;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        alu_valid_i = v.av;  alu_rd_i = v.ard;  alu_data_i = v.ad;
        lsu_issue_i = v.iv;  lsu_issue_rd_i = v.ird;
        lsu_valid_i = v.lv;  lsu_rd_i = v.lrd;  lsu_data_i = v.ld;
        dec_rs1_i = v.rs1;   dec_rs2_i = v.rs2; dec_rd_i = v.rd;
        rf_rs1_data_i = v.rf1; rf_rs2_data_i = v.rf2;
    endtask

    task automatic drive_idle();
        drive(mk(0,0,0, 0,0, 0,0,0, 0,0,0, 32'h111,32'h222, 0,0,0,0,0,0,0));
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        drive_idle();
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    vec_t vt[$];

    // Reference model state: pending loads, deferred ALU entry, write port.
    bit          pend [32];
    ent_t        skq[$];
    logic        m_we;
    logic [4:0]  m_wa;
    logic [31:0] m_wd;

    task automatic model_clear();
        foreach (pend[i]) pend[i] = 1'b0;
        skq.delete();
        m_we = 1'b0; m_wa = '0; m_wd = '0;
    endtask

    function automatic logic model_hazard(input logic [4:0] rs1, input logic [4:0] rs2,
                                          input logic [4:0] rd);
        logic h;
        h = pend[rs1] || pend[rs2] || pend[rd];
        if (skq.size() != 0 && skq[0].rd != 0 && (skq[0].rd == rs1 || skq[0].rd == rs2))
            h = 1'b1;
        return h;
    endfunction

    function automatic logic [31:0] model_byp(input logic [4:0] rs, input logic [31:0] rf);
        return (m_we && m_wa == rs && rs != 0) ? m_wd : rf;
    endfunction

    task automatic model_commit(input ent_t e);
        m_we = (e.rd != 0);
        if (e.rd != 0) begin
            m_wa = e.rd;
            m_wd = e.d;
        end
    endtask

    initial begin
        logic        hold;
        logic        rdy;
        vec_t        r;
        ent_t        e;

        rst_n = 1'b0;
        drive_idle();
        #12;
        chk("reset_we",    {31'b0, write_en_o}, 32'd0);
        chk("reset_addr",  {27'b0, write_addr_o}, 32'd0);
        chk("reset_data",  write_data_o, 32'd0);
        chk("reset_ready", {31'b0, alu_ready_o}, 32'd1);
        chk("reset_hazard",{31'b0, hazard_o}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // av ard ad | iv ird | lv lrd ld | rs1 rs2 rd | rf1 rf2 | rdy hz we wa wd | o1 o2
        vt.push_back(mk(0,0,0,          0,0, 0,0,0,          0,0,0, 32'h111,32'h222, 1,0,0,0,0,               32'h111,32'h222));
        vt.push_back(mk(1,5,32'h1234,   0,0, 0,0,0,          0,0,0, 32'h111,32'h222, 1,0,0,0,0,               32'h111,32'h222));
        vt.push_back(mk(0,0,0,          0,0, 0,0,0,          5,0,0, 32'h0,  32'h222, 1,0,1,5,32'h1234,        32'h1234,32'h222));
        vt.push_back(mk(1,3,32'hA,      0,0, 1,4,32'hB,      0,0,0, 32'h111,32'h222, 1,0,0,0,0,               32'h111,32'h222));
        vt.push_back(mk(1,6,32'hC,      0,0, 0,0,0,          3,0,0, 32'h111,32'h222, 0,1,1,4,32'hB,           32'h111,32'h222));
        vt.push_back(mk(1,6,32'hC,      0,0, 0,0,0,          3,0,0, 32'h111,32'h222, 1,0,1,3,32'hA,           32'hA,  32'h222));
        vt.push_back(mk(0,0,0,          0,0, 0,0,0,          0,6,0, 32'h111,32'h222, 1,0,1,6,32'hC,           32'h111,32'hC));
        vt.push_back(mk(0,0,0,          1,7, 0,0,0,          0,7,0, 32'h111,32'h222, 1,0,0,0,0,               32'h111,32'h222));
        vt.push_back(mk(0,0,0,          0,0, 0,0,0,          0,7,0, 32'h111,32'h222, 1,1,0,0,0,               32'h111,32'h222));
        vt.push_back(mk(0,0,0,          0,0, 0,0,0,          0,0,7, 32'h111,32'h222, 1,1,0,0,0,               32'h111,32'h222));
        vt.push_back(mk(0,0,0,          0,0, 1,7,32'h55,     0,7,0, 32'h111,32'h222, 1,1,0,0,0,               32'h111,32'h222));
        vt.push_back(mk(0,0,0,          0,0, 0,0,0,          0,7,0, 32'h111,32'h222, 1,0,1,7,32'h55,          32'h111,32'h55));
        vt.push_back(mk(0,0,0,          1,7, 1,7,32'h66,     0,7,0, 32'h111,32'h222, 1,0,0,0,0,               32'h111,32'h222));
        vt.push_back(mk(0,0,0,          0,0, 0,0,0,          0,7,0, 32'h111,32'h222, 1,1,1,7,32'h66,          32'h111,32'h66));
        vt.push_back(mk(0,0,0,          0,0, 1,7,32'h77,     0,7,0, 32'h111,32'h222, 1,1,0,0,0,               32'h111,32'h222));
        vt.push_back(mk(1,0,32'h99,     1,0, 1,0,32'h88,     0,0,0, 32'h111,32'h222, 1,0,1,7,32'h77,          32'h111,32'h222));
        vt.push_back(mk(0,0,0,          0,0, 0,0,0,          0,0,0, 32'h111,32'h222, 0,0,0,0,0,               32'h111,32'h222));
        vt.push_back(mk(0,0,0,          0,0, 0,0,0,          0,0,0, 32'h111,32'h222, 1,0,0,0,0,               32'h111,32'h222));

        foreach (vt[i]) begin
            @(posedge clk); #1;
            drive(vt[i]);
            @(negedge clk);
            chk($sformatf("vec%0d_ready", i), {31'b0, alu_ready_o}, {31'b0, vt[i].e_rdy});
            chk($sformatf("vec%0d_hazard", i), {31'b0, hazard_o}, {31'b0, vt[i].e_hz});
            chk($sformatf("vec%0d_we", i), {31'b0, write_en_o}, {31'b0, vt[i].e_we});
            if (vt[i].e_we) begin
                chk($sformatf("vec%0d_waddr", i), {27'b0, write_addr_o}, {27'b0, vt[i].e_wa});
                chk($sformatf("vec%0d_wdata", i), write_data_o, vt[i].e_wd);
            end
            chk($sformatf("vec%0d_rs1", i), rs1_data_o, vt[i].e_o1);
            chk($sformatf("vec%0d_rs2", i), rs2_data_o, vt[i].e_o2);
        end

        // Reset with the skid holding rd 9 and rd 2 pending.
        @(posedge clk); #1;
        drive(mk(0,0,0, 1,2, 0,0,0, 0,0,0, 32'h111,32'h222, 0,0,0,0,0,0,0));
        @(posedge clk); #1;
        drive(mk(1,9,32'h900, 0,0, 1,11,32'hB00, 0,0,0, 32'h111,32'h222, 0,0,0,0,0,0,0));
        @(posedge clk); #1;
        drive(mk(0,0,0, 0,0, 1,12,32'hC00, 2,9,0, 32'h111,32'h222, 0,0,0,0,0,0,0));
        @(negedge clk);
        chk("prerst_hazard", {31'b0, hazard_o}, 32'd1);
        chk("prerst_ready",  {31'b0, alu_ready_o}, 32'd0);
        chk("prerst_we",     {31'b0, write_en_o}, 32'd1);
        rst_n = 1'b0;
        drive(mk(0,0,0, 0,0, 0,0,0, 2,9,0, 32'h111,32'h222, 0,0,0,0,0,0,0));
        #1;
        chk("rst_we",     {31'b0, write_en_o}, 32'd0);
        chk("rst_addr",   {27'b0, write_addr_o}, 32'd0);
        chk("rst_data",   write_data_o, 32'd0);
        chk("rst_hazard", {31'b0, hazard_o}, 32'd0);
        chk("rst_ready",  {31'b0, alu_ready_o}, 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive(mk(0,0,0, 0,0, 1,2,32'h2222, 2,9,0, 32'h111,32'h222, 0,0,0,0,0,0,0));
        @(negedge clk);
        chk("postrst_we",     {31'b0, write_en_o}, 32'd0);
        chk("postrst_hazard", {31'b0, hazard_o}, 32'd0);
        @(posedge clk); #1;
        drive(mk(0,0,0, 0,0, 0,0,0, 2,9,0, 32'h111,32'h222, 0,0,0,0,0,0,0));
        @(negedge clk);
        chk("postrst_load_we",   {31'b0, write_en_o}, 32'd1);
        chk("postrst_load_addr", {27'b0, write_addr_o}, 32'd2);
        chk("postrst_load_rs1",  rs1_data_o, 32'h2222);
        chk("postrst_hazard2",   {31'b0, hazard_o}, 32'd0);
        chk("postrst_ready",     {31'b0, alu_ready_o}, 32'd1);

        // Randomized traffic against the reference model.
        apply_reset();
        model_clear();
        hold = 1'b0;
        r = mk(0,0,0, 0,0, 0,0,0, 0,0,0, 0,0, 0,0,0,0,0,0,0);
        for (int c = 0; c < 2000; c++) begin
            if (c != 0) begin
                @(posedge clk); #1;
            end
            if (!hold) begin
                r.av  = ($urandom_range(0, 2) != 0);
                r.ard = 5'($urandom_range(0, 7));
                r.ad  = $urandom;
            end
            r.lv  = ($urandom_range(0, 2) == 0);
            r.lrd = 5'($urandom_range(0, 7));
            r.ld  = $urandom;
            r.ird = 5'($urandom_range(0, 7));
            r.iv  = ($urandom_range(0, 3) == 0) && !pend[r.ird];
            r.rs1 = 5'($urandom_range(0, 7));
            r.rs2 = 5'($urandom_range(0, 7));
            r.rd  = 5'($urandom_range(0, 7));
            r.rf1 = $urandom;
            r.rf2 = $urandom;
            assert (!(r.iv && pend[r.ird]));
            drive(r);
            @(negedge clk);
            rdy = (skq.size() == 0);
            chk("rnd_ready",  {31'b0, alu_ready_o}, {31'b0, rdy});
            chk("rnd_hazard", {31'b0, hazard_o}, {31'b0, model_hazard(r.rs1, r.rs2, r.rd)});
            chk("rnd_we",     {31'b0, write_en_o}, {31'b0, m_we});
            if (m_we) begin
                chk("rnd_waddr", {27'b0, write_addr_o}, {27'b0, m_wa});
                chk("rnd_wdata", write_data_o, m_wd);
            end
            chk("rnd_rs1", rs1_data_o, model_byp(r.rs1, r.rf1));
            chk("rnd_rs2", rs2_data_o, model_byp(r.rs2, r.rf2));

            m_we = 1'b0;
            if (r.lv) begin
                e.rd = r.lrd; e.d = r.ld;
                model_commit(e);
                if (r.av && rdy) begin
                    e.rd = r.ard; e.d = r.ad;
                    skq.push_back(e);
                end
            end else if (skq.size() != 0) begin
                e = skq.pop_front();
                model_commit(e);
            end else if (r.av && rdy) begin
                e.rd = r.ard; e.d = r.ad;
                model_commit(e);
            end
            if (r.lv) pend[r.lrd] = 1'b0;
            if (r.iv && r.ird != 0) pend[r.ird] = 1'b1;
            hold = r.av && !rdy;
        end

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule

`default_nettype wire
